// File: rtl/top_ej1_if.sv
// Operand/selector bundle for the selective adder of top_ej1, together with
// the 4-bit selected result S that it produces.
//   data1 : operand 1, unsigned, 3 bits
//   data2 : operand 2, unsigned, 3 bits
//   sel   : adder-stage selector, 2 bits
//   sum   : selected result S, 4 bits (combinational)
// master drives operands/selector and observes S; slave is the adder.
interface top_ej1_if;
  logic [2:0] data1;
  logic [2:0] data2;
  logic [1:0] sel;
  logic [3:0] sum;

  modport master (output data1, output data2, output sel, input sum);
  modport slave  (input data1, input data2, input sel, output sum);
endinterface

// File: rtl/top_ej1.sv
// top_ej1: selectable 3-bit adder feeding a 6-bit wrapping accumulator with a
// sticky overflow flag.
// Ports:
//   clock      in   system clock, rising-edge state updates
//   i_rst_n    in   asynchronous active-low reset, clears all state
//   i_data1    in   operand 1 (3 bits, unsigned)
//   i_data2    in   operand 2 (3 bits, unsigned)
//   i_sel      in   00: data2, 01: data1+data2, 10: data1, 11: zero
//   o_data     out  accumulator value (6 bits, registered)
//   o_overflow out  sticky flag, set when the accumulator wraps past 63

// Selective adder: purely combinational choice of the 4-bit value S.
module top_ej1_seladd (
  top_ej1_if.slave add_if
);
  // Select the value to accumulate; the sum keeps its carry (max 14).
  always_comb begin
    add_if.sum = 4'd0;
    case (add_if.sel)
      2'b00:   add_if.sum = {1'b0, add_if.data2};
      2'b01:   add_if.sum = {1'b0, add_if.data1} + {1'b0, add_if.data2};
      2'b10:   add_if.sum = {1'b0, add_if.data1};
      2'b11:   add_if.sum = 4'd0;
      default: add_if.sum = 4'd0;
    endcase
  end
endmodule

// Accumulator: 6-bit modulo-64 register plus a sticky wrap flag.
module top_ej1_acc (
  input  logic       clock,
  input  logic       i_rst_n,
  input  logic [3:0] i_sum,
  output logic [5:0] o_data,
  output logic       o_overflow
);
  logic [6:0] total_s;
  logic [5:0] acc_d, acc_q;
  logic       ovf_d, ovf_q;

  // Next state: 7-bit add so the carry out of bit 5 marks a wrap.
  always_comb begin
    total_s = {1'b0, acc_q} + {3'b000, i_sum};
    acc_d   = total_s[5:0];
    if (total_s[6]) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset clears both immediately, independent of clock.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= 6'd0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_data     = acc_q;
  assign o_overflow = ovf_q;
endmodule

module top_ej1 (
  input  logic       clock,
  input  logic       i_rst_n,
  input  logic [2:0] i_data1,
  input  logic [2:0] i_data2,
  input  logic [1:0] i_sel,
  output logic [5:0] o_data,
  output logic       o_overflow
);
  // S stays visible on this bundle between the two sub-blocks.
  top_ej1_if sbus ();

  assign sbus.data1 = i_data1;
  assign sbus.data2 = i_data2;
  assign sbus.sel   = i_sel;

  top_ej1_seladd u_seladd (
    .add_if (sbus.slave)
  );

  top_ej1_acc u_acc (
    .clock      (clock),
    .i_rst_n    (i_rst_n),
    .i_sum      (sbus.sum),
    .o_data     (o_data),
    .o_overflow (o_overflow)
  );
endmodule

// File: tb/tb_top_ej1.sv
// Bench for top_ej1: directed vectors, a behavioural accumulator model checked
// every cycle, plus literal expectations from hand calculation.
module tb_top_ej1;
  logic       clock;
  logic       rst_n;
  logic [5:0] o_data;
  logic       o_overflow;

  top_ej1_if stim ();

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int m_acc = 0;
  bit m_ovf = 1'b0;
  bit chk_en = 1'b0;

  function automatic int sel_value(input int d1, input int d2, input int sel);
    if (sel == 0)      return d2;
    else if (sel == 1) return d1 + d2;
    else if (sel == 2) return d1;
    else               return 0;
  endfunction

  assign stim.sum = 4'(sel_value(int'(stim.data1), int'(stim.data2), int'(stim.sel)));

  top_ej1 dut (
    .clock      (clock),
    .i_rst_n    (rst_n),
    .i_data1    (stim.data1),
    .i_data2    (stim.data2),
    .i_sel      (stim.sel),
    .o_data     (o_data),
    .o_overflow (o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain modular arithmetic, cleared asynchronously.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= 0;
      m_ovf <= 1'b0;
    end else begin
      m_acc <= (m_acc + int'(stim.sum)) % 64;
      m_ovf <= m_ovf | ((m_acc + int'(stim.sum)) >= 64);
    end
  end

  // Per-cycle compare against the model, shortly after each rising edge.
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      check("model_data", int'(o_data), m_acc);
      check("model_ovf", int'(o_overflow), int'(m_ovf));
      check("model_s", int'(dut.sbus.sum), int'(stim.sum));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_in(input int d1, input int d2, input int sel);
    stim.data1 = 3'(d1);
    stim.data2 = 3'(d2);
    stim.sel   = 2'(sel);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    check("rst_data", int'(o_data), 0);
    check("rst_ovf", int'(o_overflow), 0);
    tick(2);
  endtask

  initial begin
    logic [3:0] s_exp [4];
    s_exp[0] = 4'd1; s_exp[1] = 4'd3; s_exp[2] = 4'd2; s_exp[3] = 4'd0;
    rst_n = 1'b0;
    set_in(2, 1, 0);
    #2;
    chk_en = 1'b1;

    // 1: S sweep under reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      set_in(2, 1, i);
      #1;
      check("t1_s", int'(dut.sbus.sum), int'(s_exp[i]));
      check("t1_data", int'(o_data), 0);
      check("t1_ovf", int'(o_overflow), 0);
    end

    // 2: +3 per edge; 63 after 21 edges, wrap to 2 on edge 22.
    @(negedge clock);
    set_in(2, 1, 1);
    rst_n = 1'b1;
    tick(1);
    check("t2_first", int'(o_data), 3);
    tick(1);
    check("t2_second", int'(o_data), 6);
    tick(19);
    check("t2_e21_data", int'(o_data), 63);
    check("t2_e21_ovf", int'(o_overflow), 0);
    tick(1);
    check("t2_e22_data", int'(o_data), 2);
    check("t2_e22_ovf", int'(o_overflow), 1);
    tick(2);

    // 3: reset between edges clears outputs at once.
    do_reset();

    // 4: +2 per edge; 62 after 31 edges, wrap to 0 on edge 32, stays sticky.
    set_in(1, 1, 1);
    rst_n = 1'b1;
    tick(31);
    check("t4_e31_data", int'(o_data), 62);
    check("t4_e31_ovf", int'(o_overflow), 0);
    tick(1);
    check("t4_e32_data", int'(o_data), 0);
    check("t4_e32_ovf", int'(o_overflow), 1);
    tick(1);
    check("t4_e33_data", int'(o_data), 2);
    tick(1);
    check("t4_e34_data", int'(o_data), 4);
    check("t4_sticky", int'(o_overflow), 1);
    do_reset();

    // 5: selector 11 never accumulates.
    set_in(7, 5, 3);
    rst_n = 1'b1;
    tick(12);
    check("t5_data", int'(o_data), 0);
    check("t5_ovf", int'(o_overflow), 0);
    do_reset();

    // 6: +14 per edge; edge 5 wraps to 6.
    set_in(7, 7, 1);
    rst_n = 1'b1;
    tick(4);
    check("t6_e4_data", int'(o_data), 56);
    check("t6_e4_ovf", int'(o_overflow), 0);
    tick(1);
    check("t6_e5_data", int'(o_data), 6);
    check("t6_e5_ovf", int'(o_overflow), 1);

    // Other selectors out of reset: data2 then data1.
    do_reset();
    set_in(5, 6, 0);
    rst_n = 1'b1;
    tick(3);
    check("sel00_data", int'(o_data), 18);
    set_in(5, 6, 2);
    tick(2);
    check("sel10_data", int'(o_data), 28);
    tick(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
